// File: rtl/keyed_irq_pkg.sv
// Shared types and width helpers for the keyed interrupt controller.
package keyed_irq_pkg;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    LOAD     = 2'd1,
    CHECK    = 2'd2,
    UNLOCKED = 2'd3
  } key_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Width needed to hold a count from 0 to n inclusive.
  function automatic int cnt_w(input int n);
    return idx_w(n + 1);
  endfunction

endpackage

// File: rtl/keyed_irq_arb.sv
// Combinational two-level priority encoder: lowest enabled bus with any
// pending bit wins, then the lowest pending channel inside that bus.
module keyed_irq_arb
  import keyed_irq_pkg::*;
#(
  parameter int NUM_BUS = 3,
  parameter int NUM_CH  = 9
) (
  input  logic [NUM_BUS*NUM_CH-1:0] pend,
  input  logic [NUM_BUS-1:0]        bus_en,
  output logic                      any,
  output logic [idx_w(NUM_BUS)-1:0] win_bus,
  output logic [idx_w(NUM_CH)-1:0]  win_chan,
  output logic [NUM_BUS*NUM_CH-1:0] clr
);

  localparam int BUS_W = idx_w(NUM_BUS);
  localparam int CH_W  = idx_w(NUM_CH);

  logic [NUM_BUS-1:0] bus_hit;
  logic [NUM_CH-1:0]  row;

  // Bus level: scan from the top so the lowest hit index is left standing.
  always_comb begin
    bus_hit = '0;
    win_bus = '0;
    for (int b = NUM_BUS - 1; b >= 0; b--) begin
      bus_hit[b] = (|pend[b*NUM_CH +: NUM_CH]) & bus_en[b];
      if (bus_hit[b]) win_bus = BUS_W'(b);
    end
    any = |bus_hit;
  end

  // Channel level inside the winning bus, plus the one-hot clear vector.
  always_comb begin
    row      = '0;
    win_chan = '0;
    clr      = '0;
    for (int b = 0; b < NUM_BUS; b++) begin
      if (win_bus == BUS_W'(b)) row = pend[b*NUM_CH +: NUM_CH];
    end
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (row[c]) win_chan = CH_W'(c);
    end
    for (int b = 0; b < NUM_BUS; b++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        clr[b*NUM_CH + c] = any && (win_bus == BUS_W'(b)) && (win_chan == CH_W'(c));
      end
    end
  end

endmodule

// File: rtl/keyed_irq_ctrl.sv
// Key-locked, registered priority interrupt controller with sticky pending
// bits and a valid/ack grant handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// LOCKED   | no valid key; granted channel numbers are scrambled
// LOAD     | shifting in key bits MSB first, counting valid bits
// CHECK    | full key captured; compared against KEY_VALUE this cycle
// UNLOCKED | last key load matched; channel numbers are reported clean
module keyed_irq_ctrl
  import keyed_irq_pkg::*;
#(
  parameter int               NUM_BUS   = 3,
  parameter int               NUM_CH    = 9,
  parameter int               KEY_W     = 29,
  parameter logic [KEY_W-1:0] KEY_VALUE = '0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_BUS*NUM_CH-1:0]           req,
  input  logic [NUM_BUS-1:0]                  bus_en,
  input  logic                                key_bit,
  input  logic                                key_vld,
  input  logic                                key_start,
  output logic                                irq_valid,
  output logic [idx_w(NUM_BUS)-1:0]           irq_bus,
  output logic [idx_w(NUM_CH)-1:0]            irq_chan,
  input  logic                                irq_ack,
  output logic                                unlocked,
  output logic [cnt_w(NUM_BUS*NUM_CH)-1:0]    pend_cnt
);

  localparam int N      = NUM_BUS * NUM_CH;
  localparam int BUS_W  = idx_w(NUM_BUS);
  localparam int CH_W   = idx_w(NUM_CH);
  localparam int CNT_W  = cnt_w(N);
  localparam int KCNT_W = cnt_w(KEY_W);

  key_state_e        state, state_nxt;
  logic [KEY_W-1:0]  key_sr;
  logic [KCNT_W-1:0] key_cnt;
  logic [CH_W-1:0]   key_scramble;

  logic [N-1:0]      pend, pend_nxt, en_mask, grant_clr;
  logic              accept;
  logic              arb_any;
  logic [BUS_W-1:0]  arb_bus;
  logic [CH_W-1:0]   arb_chan;
  logic [N-1:0]      arb_clr;

  keyed_irq_arb #(
    .NUM_BUS (NUM_BUS),
    .NUM_CH  (NUM_CH)
  ) u_arb (
    .pend     (pend),
    .bus_en   (bus_en),
    .any      (arb_any),
    .win_bus  (arb_bus),
    .win_chan (arb_chan),
    .clr      (arb_clr)
  );

  assign accept       = irq_valid & irq_ack;
  assign unlocked     = (state == UNLOCKED);
  assign key_scramble = CH_W'(key_sr ^ KEY_VALUE);

  // Spread each bus enable across that bus's channel bits.
  always_comb begin
    en_mask = '0;
    for (int b = 0; b < NUM_BUS; b++) begin
      en_mask[b*NUM_CH +: NUM_CH] = {NUM_CH{bus_en[b]}};
    end
  end

  // Only the accepted grant clears; a fresh request on the same bit wins.
  assign pend_nxt = (pend & ~(accept ? grant_clr : '0)) | (req & en_mask);

  // Pending bits and their population count, both updated on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      pend_cnt <= CNT_W'($countones(pend_nxt));
    end
  end

  // Grant register: hold while unacked, drop for one cycle after accept,
  // otherwise load the current winner. The clear vector travels with the
  // grant so a later higher-priority request cannot redirect the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_valid <= 1'b0;
      irq_bus   <= '0;
      irq_chan  <= '0;
      grant_clr <= '0;
    end else if (accept) begin
      irq_valid <= 1'b0;
    end else if (!irq_valid && arb_any) begin
      irq_valid <= 1'b1;
      irq_bus   <= arb_bus;
      irq_chan  <= arb_chan ^ (unlocked ? '0 : key_scramble);
      grant_clr <= arb_clr;
    end
  end

  // Key FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOCKED;
    else     state <= state_nxt;
  end

  // Key FSM next state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOCKED, UNLOCKED: if (key_start) state_nxt = LOAD;
      LOAD: begin
        if (key_start)                                           state_nxt = LOAD;
        else if (key_vld && key_cnt == KCNT_W'(KEY_W - 1))       state_nxt = CHECK;
      end
      CHECK:   state_nxt = (key_sr == KEY_VALUE) ? UNLOCKED : LOCKED;
      default: state_nxt = LOCKED;
    endcase
  end

  // Key shift register and bit counter; every accepted key_start begins a
  // clean load so leftovers of a previous key never leak into the compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_sr  <= '0;
      key_cnt <= '0;
    end else if (key_start && state != CHECK) begin
      key_sr  <= '0;
      key_cnt <= '0;
    end else if (state == LOAD && key_vld) begin
      key_sr  <= {key_sr[KEY_W-2:0], key_bit};
      key_cnt <= key_cnt + KCNT_W'(1);
    end
  end

endmodule
